// File: rtl/systolic_ctrl_pkg.sv
// Shared types for the systolic array sequencer and its PEs.
// Row mux encoding is shared with the PE; state names carry an ST_ prefix so they do not collide with the mux literals.
package systolic_ctrl_pkg;

   typedef enum logic [1:0] {
      PASSTHROUGH = 2'd0,
      LOAD        = 2'd1,
      PROCESS     = 2'd2
   } input_mux_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COMPUTE,
      ST_DONE
   } ctrl_state_t;

   localparam int PERF_CYCLES_W = 32;
   localparam int PERF_JOBS_W   = 16;

   // Phase counter must hold the longest COMPUTE index: LEN_max + ROWS + COLS - 2.
   function automatic int phase_cnt_w(input int len_w, input int rows, input int cols);
      return $clog2((1 << len_w) + rows + cols);
   endfunction

endpackage

// File: rtl/systolic_ctrl_col_valid.sv
// Per-column output-valid window: column c is valid for phase in [ROWS+c, ROWS+c+LEN-1].
module ctrl_col_valid
   import systolic_ctrl_pkg::*;
#(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int LEN_W = 8,
   parameter int CNT_W = 9
) (
   input  logic             active,
   input  logic [CNT_W-1:0] phase,
   input  logic [LEN_W-1:0] len,
   output logic [COLS-1:0]  out_valid
);

   genvar gi;
   generate
      for (gi = 0; gi < COLS; gi++) begin : g_col
         localparam logic [CNT_W-1:0] FIRST = CNT_W'(ROWS + gi);
         logic [CNT_W-1:0] end_excl;

         // Exclusive upper bound avoids a subtract; cannot overflow for the counter width chosen.
         assign end_excl       = FIRST + CNT_W'(len);
         assign out_valid[gi]  = active && (phase >= FIRST) && (phase < end_excl);
      end
   endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// Weight-stationary systolic array sequencer: LOAD weights, COMPUTE activations, DONE pulse.
// Optional performance counters are built when SYSTOLIC_CTRL_PERF_EN is defined.
module systolic_ctrl
   import systolic_ctrl_pkg::*;
#(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int LEN_W = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic [LEN_W-1:0]         len_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     wgt_rd_o,
   output logic [$clog2(ROWS)-1:0]  wgt_row_o,
   output logic                     act_rd_o,
   output logic [LEN_W-1:0]         act_idx_o,
   output logic [2*ROWS-1:0]        mux_o,
   output logic [ROWS-1:0]          add_zero_o,
   output logic [COLS-1:0]          out_valid_o
`ifdef SYSTOLIC_CTRL_PERF_EN
   ,
   output logic [PERF_CYCLES_W-1:0] job_cycles_o,
   output logic [PERF_JOBS_W-1:0]   jobs_o
`endif
);

   localparam int ROW_W = $clog2(ROWS);
   localparam int CNT_W = phase_cnt_w(LEN_W, ROWS, COLS);
   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(ROWS - 1);

   ctrl_state_t      state_reg, state_next;
   logic [CNT_W-1:0] phase_reg, phase_next;
   logic [LEN_W-1:0] len_reg;
   logic [CNT_W-1:0] compute_last;
   logic             in_load, in_compute;
   input_mux_t       row_mode;

   assign compute_last = CNT_W'(len_reg) + CNT_W'(ROWS + COLS - 2);
   assign in_load      = (state_reg == ST_LOAD);
   assign in_compute   = (state_reg == ST_COMPUTE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= ST_IDLE;
         phase_reg <= '0;
         len_reg   <= '0;
      end else begin
         state_reg <= state_next;
         phase_reg <= phase_next;
         if (state_reg == ST_IDLE && start_i && (len_i != '0))
            len_reg <= len_i;
      end
   end

   // The phase counter restarts on every state entry.
   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg + 1'b1;
      case (state_reg)
         ST_IDLE: begin
            phase_next = '0;
            if (start_i && (len_i != '0))
               state_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (phase_reg == LOAD_LAST) begin
               state_next = ST_COMPUTE;
               phase_next = '0;
            end
         end
         ST_COMPUTE: begin
            if (phase_reg == compute_last) begin
               state_next = ST_DONE;
               phase_next = '0;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
            phase_next = '0;
         end
         default: begin
            state_next = ST_IDLE;
            phase_next = '0;
         end
      endcase
   end

   always_comb begin
      busy_o     = in_load || in_compute;
      done_o     = (state_reg == ST_DONE);
      wgt_rd_o   = in_load;
      wgt_row_o  = '0;
      act_rd_o   = 1'b0;
      act_idx_o  = '0;
      add_zero_o = '0;
      row_mode   = PASSTHROUGH;
      if (in_load) begin
         // Bottom row first so every row latches its own weight on the final LOAD cycle.
         wgt_row_o = ROW_W'(ROWS - 1) - phase_reg[ROW_W-1:0];
         if (phase_reg == LOAD_LAST)
            row_mode = LOAD;
      end
      if (in_compute) begin
         row_mode      = PROCESS;
         add_zero_o[0] = 1'b1;
         if (phase_reg < CNT_W'(len_reg)) begin
            act_rd_o  = 1'b1;
            act_idx_o = phase_reg[LEN_W-1:0];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_row_mux
         assign mux_o[2*gi +: 2] = row_mode;
      end
   endgenerate

   ctrl_col_valid #(
      .ROWS  (ROWS),
      .COLS  (COLS),
      .LEN_W (LEN_W),
      .CNT_W (CNT_W)
   ) u_col_valid (
      .active    (in_compute),
      .phase     (phase_reg),
      .len       (len_reg),
      .out_valid (out_valid_o)
   );

`ifdef SYSTOLIC_CTRL_PERF_EN
   logic [PERF_CYCLES_W-1:0] busy_cnt_reg;
   logic [PERF_CYCLES_W-1:0] job_cycles_reg;
   logic [PERF_JOBS_W-1:0]   jobs_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_cnt_reg   <= '0;
         job_cycles_reg <= '0;
         jobs_reg       <= '0;
      end else begin
         if (state_reg == ST_IDLE)
            busy_cnt_reg <= '0;
         else if (busy_o)
            busy_cnt_reg <= busy_cnt_reg + 1'b1;
         if (state_reg == ST_DONE) begin
            job_cycles_reg <= busy_cnt_reg;
            jobs_reg       <= jobs_reg + 1'b1;
         end
      end
   end

   assign job_cycles_o = job_cycles_reg;
   assign jobs_o       = jobs_reg;
`endif

endmodule
